// File: rtl/packet_serializer_pkg.sv
// Shared constants and FSM state type for the packet serializer.
package packet_serializer_pkg;

  localparam int unsigned HEADER_SIZE = 64;
  localparam int unsigned FOOTER_SIZE = 64;
  localparam logic [63:0] FOOTER_WORD = 64'hA5A5_5A5A_C0DE_F00D;
  localparam logic [7:0]  ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    TERM = 2'd3
  } state_e;

endpackage

// File: rtl/packet_serializer_hex_ascii_enc.sv
// Combinational nibble to upper-case ASCII hex digit encoder.
module hex_ascii_enc (
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  // '0'..'9' are 0x30..0x39, 'A'..'F' are 0x41..0x46 (0x37 + 10..15).
  always_comb begin
    if (nibble < 4'd10) begin
      ascii_c = 8'h30 + 8'(nibble);
    end else begin
      ascii_c = 8'h37 + 8'(nibble);
    end
  end

endmodule

// File: rtl/packet_serializer.sv
// Snapshots a free-running timestamp and the correlator accumulators, then
// streams {timestamp, pulses, footer} MSB first over a valid/ready byte port.
module packet_serializer
  import packet_serializer_pkg::*;
#(
  parameter int unsigned PAYLOAD_SIZE = 48,
  parameter int unsigned BINARY       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [PAYLOAD_SIZE-1:0] pulses,
  output logic                    clear_acc,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned PACKET_SIZE = HEADER_SIZE + PAYLOAD_SIZE + FOOTER_SIZE;
  localparam int unsigned STEP        = (BINARY != 0) ? 8 : 4;
  localparam int unsigned NUM_XFER    = PACKET_SIZE / STEP;
  localparam int unsigned CNT_W       = $clog2(PACKET_SIZE / 4) + 1;

  state_e                 state_q, state_d;
  logic [63:0]            timestamp_q, timestamp_d;
  logic [PACKET_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   clear_acc_q, clear_acc_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;

  logic       xfer_c;
  logic [3:0] nib_c;
  logic [7:0] hex_c;
  logic [7:0] byte_c;

  assign xfer_c = tx_valid_q & tx_ready;

  // Next-state, shift register, transfer counter and sticky overrun.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    timestamp_d = timestamp_q + 64'd1;
    overrun_d   = overrun_q | (start & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = {timestamp_q, pulses, FOOTER_WORD};
        cnt_d   = CNT_W'(NUM_XFER);
        state_d = SEND;
      end
      SEND: begin
        if (xfer_c) begin
          shift_d = shift_q << STEP;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = (BINARY != 0) ? IDLE : TERM;
          end
        end
      end
      TERM: begin
        if (xfer_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The next offered byte comes from the post-shift register so it is
  // registered alongside the shift and stays put while stalled.
  assign nib_c = shift_d[PACKET_SIZE-1 -: 4];

  hex_ascii_enc u_hex_ascii_enc (
    .nibble  (nib_c),
    .ascii_c (hex_c)
  );

  assign byte_c = (BINARY != 0) ? shift_d[PACKET_SIZE-1 -: 8] : hex_c;

  // Registered outputs follow the next state.
  always_comb begin
    tx_valid_d  = 1'b0;
    tx_data_d   = 8'h00;
    busy_d      = (state_d != IDLE);
    clear_acc_d = (state_d == LOAD);
    case (state_d)
      SEND: begin
        tx_valid_d = 1'b1;
        tx_data_d  = byte_c;
      end
      TERM: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_CR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timestamp_q <= 64'd0;
      shift_q     <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      clear_acc_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timestamp_q <= timestamp_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      clear_acc_q <= clear_acc_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
    end
  end

  assign clear_acc = clear_acc_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench: binary and ASCII serializers side by side, PAYLOAD_SIZE=16.
module tb_packet_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pulses;
  logic        rdy_b, rdy_h;
  logic        ca_b, ca_h, tv_b, tv_h, busy_b, busy_h, ovr_b, ovr_h;
  logic [7:0]  td_b, td_h;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] qb[$];
  logic [7:0] qh[$];
  int         clr_b, clr_h;
  bit         bp;
  bit         stall_b, stall_h, last_b, last_h;
  logic [7:0] held_b, held_h;

  logic [7:0] lit_b [18] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06,
                             8'hA5, 8'hC3, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'hC0, 8'hDE,
                             8'hF0, 8'h0D};
  string      lit_h = "0000000000000006A5C3A5A55A5AC0DEF00D";

  always #5 clk = ~clk;

  packet_serializer #(.PAYLOAD_SIZE(16), .BINARY(1)) u_bin (
    .clk(clk), .reset(reset), .start(start), .pulses(pulses),
    .clear_acc(ca_b), .tx_data(td_b), .tx_valid(tv_b), .tx_ready(rdy_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  packet_serializer #(.PAYLOAD_SIZE(16), .BINARY(0)) u_hex (
    .clk(clk), .reset(reset), .start(start), .pulses(pulses),
    .clear_acc(ca_h), .tx_data(td_h), .tx_valid(tv_h), .tx_ready(rdy_h),
    .busy(busy_h), .overrun(ovr_h)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference packet: {snapshot, 16'hA5C3, footer}, bytes or hex chars then CR.
  function automatic logic [7:0] exp_byte(input bit bin, input logic [63:0] snap, input int i);
    logic [143:0] pkt;
    logic [3:0]   nb;
    pkt = {snap, 16'hA5C3, 64'hA5A5_5A5A_C0DE_F00D};
    if (bin) return pkt[143-8*i -: 8];
    if (i == 36) return 8'h0D;
    nb = pkt[143-4*i -: 4];
    return (nb < 4'd10) ? 8'(8'h30 + 8'(nb)) : 8'(8'h37 + 8'(nb));
  endfunction

  task automatic sample();
    if (stall_b) begin
      chk("bin_stall_valid", 64'(tv_b), 64'd1);
      chk("bin_stall_data", 64'(td_b), 64'(held_b));
    end
    if (stall_h) begin
      chk("hex_stall_valid", 64'(tv_h), 64'd1);
      chk("hex_stall_data", 64'(td_h), 64'(held_h));
    end
    if (last_b) chk("bin_busy_after_last", 64'(busy_b), 64'd0);
    if (last_h) chk("hex_busy_after_cr", 64'(busy_h), 64'd0);
    last_b = 1'b0;
    last_h = 1'b0;
    if (tv_b && rdy_b) begin
      qb.push_back(td_b);
      last_b = (qb.size() == 18);
    end
    if (tv_h && rdy_h) begin
      qh.push_back(td_h);
      last_h = (qh.size() == 37);
    end
    stall_b = tv_b && !rdy_b;
    stall_h = tv_h && !rdy_h;
    held_b  = td_b;
    held_h  = td_h;
    if (ca_b) clr_b++;
    if (ca_h) clr_h++;
  endtask

  task automatic step(input logic s);
    @(negedge clk);
    start = s;
    if (bp) begin
      rdy_b = 1'($urandom_range(0, 1));
      rdy_h = 1'($urandom_range(0, 1));
    end else begin
      rdy_b = 1'b1;
      rdy_h = 1'b1;
    end
    sample();
  endtask

  task automatic clear_log();
    qb.delete();
    qh.delete();
    clr_b = 0; clr_h = 0;
    stall_b = 1'b0; stall_h = 1'b0;
    last_b = 1'b0; last_h = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_valid_b", 64'(tv_b), 64'd0);
    chk("rst_valid_h", 64'(tv_h), 64'd0);
    chk("rst_data_b", 64'(td_b), 64'd0);
    chk("rst_data_h", 64'(td_h), 64'd0);
    chk("rst_clear_b", 64'(ca_b), 64'd0);
    chk("rst_clear_h", 64'(ca_h), 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    chk("rst_busy_h", 64'(busy_h), 64'd0);
    chk("rst_overrun_b", 64'(ovr_b), 64'd0);
    chk("rst_overrun_h", 64'(ovr_h), 64'd0);
    clear_log();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Start pulse now; expect header = snap (timestamp one cycle later).
  task automatic run_packet(input logic [63:0] snap, input bit bpm, input bit ovr, input bit lit);
    logic [7:0] obs;
    clear_log();
    bp = bpm;
    step(1'b1);
    chk("start_cycle_valid_b", 64'(tv_b), 64'd0);
    chk("start_cycle_busy_h", 64'(busy_h), 64'd0);
    step(1'b0);
    chk("load_clear_b", 64'(ca_b), 64'd1);
    chk("load_clear_h", 64'(ca_h), 64'd1);
    chk("load_busy_b", 64'(busy_b), 64'd1);
    chk("load_valid_h", 64'(tv_h), 64'd0);
    step(1'b0);
    pulses = 16'h0F0F;
    chk("first_valid_b", 64'(tv_b), 64'd1);
    chk("first_valid_h", 64'(tv_h), 64'd1);
    chk("first_data_b", 64'(td_b), 64'(exp_byte(1'b1, snap, 0)));
    chk("first_data_h", 64'(td_h), 64'(exp_byte(1'b0, snap, 0)));
    step(ovr);
    repeat (160) step(1'b0);
    bp = 1'b0;
    chk("bin_count", 64'(qb.size()), 64'd18);
    chk("hex_count", 64'(qh.size()), 64'd37);
    for (int i = 0; i < 18; i++) begin
      obs = (i < qb.size()) ? qb[i] : 8'hEE;
      chk($sformatf("bin_byte%0d", i), 64'(obs), 64'(exp_byte(1'b1, snap, i)));
      if (lit) chk($sformatf("bin_lit%0d", i), 64'(obs), 64'(lit_b[i]));
    end
    for (int i = 0; i < 37; i++) begin
      obs = (i < qh.size()) ? qh[i] : 8'hEE;
      chk($sformatf("hex_char%0d", i), 64'(obs), 64'(exp_byte(1'b0, snap, i)));
      if (lit && i < 36) chk($sformatf("hex_lit%0d", i), 64'(obs), 64'(lit_h[i]));
    end
    chk("clear_pulses_b", 64'(clr_b), 64'd1);
    chk("clear_pulses_h", 64'(clr_h), 64'd1);
    chk("overrun_b", 64'(ovr_b), 64'(ovr));
    chk("overrun_h", 64'(ovr_h), 64'(ovr));
    chk("end_busy_b", 64'(busy_b), 64'd0);
    chk("end_busy_h", 64'(busy_h), 64'd0);
    pulses = 16'hA5C3;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    pulses = 16'hA5C3;
    rdy_b  = 1'b1;
    rdy_h  = 1'b1;
    bp     = 1'b0;

    // Nominal packet, start while timestamp is 5.
    do_reset();
    repeat (4) step(1'b0);
    run_packet(64'd6, 1'b0, 1'b0, 1'b1);

    // Random backpressure.
    do_reset();
    repeat (4) step(1'b0);
    run_packet(64'd6, 1'b1, 1'b0, 1'b0);

    // Second start right after the first transfer is dropped.
    do_reset();
    repeat (4) step(1'b0);
    run_packet(64'd6, 1'b0, 1'b1, 1'b0);

    // Reset after five bytes, then a fresh packet.
    do_reset();
    repeat (4) step(1'b0);
    step(1'b1);
    repeat (6) step(1'b0);
    chk("abort_bytes_b", 64'(qb.size()), 64'd5);
    chk("abort_bytes_h", 64'(qh.size()), 64'd5);
    do_reset();
    repeat (4) step(1'b0);
    run_packet(64'd6, 1'b0, 1'b0, 1'b0);

    // Timestamp wrap.
    do_reset();
    step(1'b0);
    force u_bin.timestamp_q = 64'hFFFF_FFFF_FFFF_FFFE;
    force u_hex.timestamp_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release u_bin.timestamp_q;
    release u_hex.timestamp_q;
    repeat (3) step(1'b0);
    chk("wrap_ts_b", u_bin.timestamp_q, 64'd1);
    chk("wrap_ts_h", u_hex.timestamp_q, 64'd1);
    run_packet(64'd3, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 SHALL have parameter PAYLOAD_SIZE, default 48: width in bits of the accumulator vector; must be a multiple of 8.
REQ-002 SHALL have parameter BINARY, default 0: 0 = ASCII hex output, 1 = raw byte output.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to emit one packet.
REQ-006 SHALL have port pulses, input, PAYLOAD_SIZE: the accumulator vector produced by the correlator.
REQ-007 SHALL have port clear_acc, output, 1: one-cycle pulse commanding the correlator to zero its accumulators.
REQ-008 SHALL have port tx_data, output, 8: the byte offered to the UART transmitter.
REQ-009 SHALL have port tx_valid, output, 1: tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1: the transmitter accepts tx_data.
REQ-011 SHALL have port busy, output, 1: a packet is in progress.
REQ-012 SHALL have port overrun, output, 1: sticky flag set when start is dropped.

Function
REQ-013 SHALL keep a 64-bit free-running timestamp that increments every clk cycle and wraps from 2^64-1 to 0.
REQ-014 SHALL use a packet of PACKET_SIZE = 64 + PAYLOAD_SIZE + 64 bits, made of {timestamp snapshot, pulses snapshot, FOOTER_WORD}, sent MSB first.
REQ-015 SHALL implement an FSM with states IDLE, LOAD, SEND and TERM; reset enters IDLE.
REQ-016 SHALL go IDLE->LOAD when start=1 in IDLE; in LOAD it SHALL capture timestamp and pulses into the shift register and assert clear_acc for exactly that cycle.
REQ-017 SHALL go LOAD->SEND on the next cycle, so the first tx_valid appears 2 cycles after start.
REQ-018 In SEND with BINARY=1, SHALL emit PACKET_SIZE/8 bytes, most significant byte first.
REQ-019 In SEND with BINARY=0, SHALL emit PACKET_SIZE/4 characters, one per nibble, MSB nibble first; nibble 0-9 maps to 0x30-0x39 and A-F maps to 0x41-0x46.
REQ-020 SHALL follow valid/ready handshake rules: a byte transfers when tx_valid & tx_ready; tx_data stays stable while tx_valid=1 & tx_ready=0; tx_valid never drops without a transfer.
REQ-021 SHALL go SEND->TERM after the last payload transfer when BINARY=0; TERM emits 0x0D and goes to IDLE on transfer.
REQ-022 SHALL go SEND->IDLE after the last transfer when BINARY=1.
REQ-023 SHALL hold busy=1 in every state except IDLE.
REQ-024 When start=1 while busy=1, SHALL ignore the request and set overrun=1; overrun clears only on reset.
REQ-025 When start=1 in the same cycle the FSM returns to IDLE, SHALL ignore the request (busy still 1) and set overrun.
REQ-026 Changes on pulses after LOAD SHALL NOT affect the packet in flight.
REQ-027 SHALL count transfers with a down-counter sized $clog2(PACKET_SIZE/4)+1, loaded in LOAD; the FSM leaves SEND on the transfer with counter == 1.

Reset
REQ-028 While reset=0, SHALL force asynchronously: state=IDLE, tx_valid=0, tx_data=0, clear_acc=0, busy=0, overrun=0, timestamp=0, shift register=0, counter=0.
REQ-029 A reset asserted mid-packet SHALL abandon the packet with no further bytes; the first start after release produces a complete new packet.

Structure
REQ-030 A shared package SHALL hold HEADER_SIZE=64, FOOTER_SIZE=64, FOOTER_WORD=64'hA5A5_5A5A_C0DE_F00D, ASCII_CR=8'h0D and the state enum.
REQ-031 The nibble-to-ASCII mapping SHALL be a sub-module hex_ascii_enc (4-bit in, 8-bit out, combinational).
REQ-032 Shifting SHALL use one PACKET_SIZE-bit register shifted by 8 (BINARY=1) or 4 (BINARY=0) per transfer.

Verification
REQ-033 Binary: BINARY=1, PAYLOAD_SIZE=16, tx_ready=1, pulses=16'hA5C3, start at timestamp 5 -> 18 bytes, namely 00×7, 06 (snapshot taken one cycle after start), A5, C3, A5, A5, 5A, 5A, C0, DE, F0, 0D; clear_acc for 1 cycle.
REQ-034 ASCII: same stimulus with BINARY=0 -> 36 characters "0000000000000006A5C3A5A55A5AC0DEF00D", then 0x0D; busy drops the cycle after CR is accepted.
REQ-035 Backpressure: tx_ready toggles randomly -> tx_data is stable while stalled, no byte is lost or duplicated, and the byte sequence matches the REQ-033 case.
REQ-036 Overrun: start pulsed in the cycle after the first transfer -> overrun=1, the packet is unchanged, and no second packet is sent.
REQ-037 Mid-packet reset: reset=0 after 5 bytes -> all outputs are 0 immediately; release then start -> a complete packet with timestamp restarted from 0.
REQ-038 Wrap: timestamp preloaded via force to 2^64-2, run 3 cycles -> value 1; header bytes reflect the snapshot.
